// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA capture path: frame geometry,
// frame-buffer write record and the capture state encoding.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int ADDR_W   = 19;
    localparam int PIX_W    = 24;

    typedef enum logic [1:0] {
        IDLE,
        SYNC_WAIT,
        ACTIVE
    } cap_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } pix_wr_t;

    // y*640 + x without a multiplier, same layout the display side reads.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] y,
                                                   input logic [ADDR_W-1:0] x);
        return (y << 9) + (y << 7) + x;
    endfunction

endpackage

// File: rtl/vga_capture_fifo.sv
// Small synchronous FIFO of frame-buffer write records; the head is read
// straight out of registered storage so outputs never depend on this cycle's push.
module capture_fifo
    import vga_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic    clk,
    input  logic    clrn,
    input  logic    push,
    input  logic    pop,
    input  pix_wr_t din,
    output logic    full,
    output logic    empty,
    output pix_wr_t head
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    pix_wr_t       mem_q [FIFO_DEPTH];
    logic          do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign wr_ptr_d = wr_ptr_q + PW'(do_push);
    assign rd_ptr_d = rd_ptr_q + PW'(do_pop);
    assign head     = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/vga_capture.sv
// VGA pixel-stream capture: follows vsync/valid framing, writes each active
// pixel to a linear frame buffer via a FIFO and reports frame/line health.
module vga_capture
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              valid,
    input  logic [7:0]        vga_r,
    input  logic [7:0]        vga_g,
    input  logic [7:0]        vga_b,
    input  logic              capture_en,
    input  logic              err_clr,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              line_err,
    output logic              overflow
);

    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0] H_LIM = XW'(H_ACTIVE);
    localparam logic [YW-1:0] V_LIM = YW'(V_ACTIVE);

    cap_state_e    state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          vs_q, hs_q, vld_q;
    logic          frame_err_q, frame_err_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          line_err_q, line_err_d;
    logic          overflow_q, overflow_d;
    logic          vs_rise, vs_fall, vld_fall, in_range;
    logic          push, pop, fifo_full, fifo_empty, line_err_set;
    pix_wr_t       push_ent, head;
    logic          unused_hs;

    // Lines are delimited by valid; hsync is only kept registered alongside.
    assign unused_hs = hs_q;

    assign vs_rise  = vsync & ~vs_q;
    assign vs_fall  = ~vsync & vs_q;
    assign vld_fall = ~valid & vld_q;
    assign in_range = (x_q < H_LIM) && (y_q < V_LIM);
    assign push_ent = {pix_addr(ADDR_W'(y_q), ADDR_W'(x_q)), vga_r, vga_g, vga_b};
    assign pop      = ~fifo_empty & wr_ready;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        frame_err_d  = frame_err_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        line_err_set = 1'b0;
        push         = 1'b0;
        case (state_q)
            IDLE: if (capture_en) state_d = SYNC_WAIT;
            SYNC_WAIT: begin
                if (vs_rise) begin
                    if (capture_en) begin
                        state_d     = ACTIVE;
                        x_d         = '0;
                        y_d         = '0;
                        frame_err_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ACTIVE: begin
                if (valid) begin
                    if (in_range) begin
                        push = 1'b1;
                        x_d  = x_q + 1'b1;
                    end else begin
                        line_err_set = 1'b1;
                    end
                end
                if (vld_fall) begin
                    if (x_q != H_LIM) begin
                        line_err_set = 1'b1;
                        frame_err_d  = 1'b1;
                    end
                    x_d = '0;
                    y_d = (y_q == V_LIM) ? y_q : y_q + 1'b1;
                end
                // Frame check sees the line close from this same cycle.
                if (vs_fall) begin
                    if (y_d == V_LIM && !frame_err_d) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 1'b1;
                    end else begin
                        line_err_set = 1'b1;
                    end
                    state_d = SYNC_WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
        line_err_d = (line_err_q & ~err_clr) | line_err_set;
        overflow_d = (overflow_q & ~err_clr) | (push & fifo_full & ~pop);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            vs_q         <= 1'b1;
            hs_q         <= 1'b1;
            vld_q        <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            line_err_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            vs_q         <= vsync;
            hs_q         <= hsync;
            vld_q        <= valid;
            frame_err_q  <= frame_err_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            line_err_q   <= line_err_d;
            overflow_q   <= overflow_d;
        end
    end

    capture_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .clrn (clrn),
        .push (push),
        .pop  (pop),
        .din  (push_ent),
        .full (fifo_full),
        .empty(fifo_empty),
        .head (head)
    );

    assign wr_valid   = ~fifo_empty;
    assign wr_addr    = head.addr;
    assign wr_data    = head.data;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign line_err   = line_err_q;
    assign overflow   = overflow_q;

endmodule
